// File: rtl/xs3_to_bcd_serial_decoder_if.sv
// Serial Excess-3 in / decoded BCD out bundle for the serial Excess-3 to BCD decoder.
`timescale 1ns/1ps
interface xs3_to_bcd_serial_decoder_if #(
  parameter int DIGITS = 4
);
  logic                  x;
  logic                  x_valid;
  logic                  y;
  logic                  y_valid;
  logic [1:0]            bit_idx;
  logic [3:0]            digit;
  logic                  digit_valid;
  logic                  code_err;
  logic [4*DIGITS-1:0]   bcd_word;
  logic                  word_valid;
  logic                  word_err;

  modport master (
    output x, x_valid,
    input  y, y_valid, bit_idx, digit, digit_valid, code_err,
           bcd_word, word_valid, word_err
  );

  modport slave (
    input  x, x_valid,
    output y, y_valid, bit_idx, digit, digit_valid, code_err,
           bcd_word, word_valid, word_err
  );
endinterface

// File: rtl/xs3_to_bcd_serial_decoder.sv
// Serial Mealy Excess-3 to BCD decoder: subtracts 0011 bit-serially (LSB first),
// assembles each decoded digit, flags codes outside 3..12 and packs DIGITS digits per word.
`timescale 1ns/1ps
module xs3_to_bcd_serial_decoder #(
  parameter int DIGITS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  xs3_to_bcd_serial_decoder_if.slave      bus
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // N/B suffix: borrow not pending / pending into the current bit position
  typedef enum logic [2:0] {S0, S1N, S1B, S2N, S2B, S3N, S3B} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                w_y;
  logic                w_lastBit;
  logic [3:0]          w_code;
  logic [3:0]          w_digit;
  logic                w_codeErr;
  logic [4*DIGITS-1:0] w_stageNext;

  logic [1:0]          r_bitIdx;
  logic [2:0]          r_codeSh;
  logic [2:0]          r_ySh;
  logic [3:0]          r_digit;
  logic                r_digitValid;
  logic                r_codeErr;
  logic [CW-1:0]       r_cnt;
  logic                r_sticky;
  logic [4*DIGITS-1:0] r_stage;
  logic [4*DIGITS-1:0] r_bcdWord;
  logic                r_wordValid;
  logic                r_wordErr;

  always_comb begin
    w_y         = 1'b0;
    w_nextState = r_state;
    case (r_state)
      S0: begin
        w_y         = ~bus.x;
        w_nextState = bus.x ? S1N : S1B;
      end
      S1N: begin
        w_y         = ~bus.x;
        w_nextState = bus.x ? S2N : S2B;
      end
      S1B: begin
        w_y         = bus.x;
        w_nextState = S2B;
      end
      S2N: begin
        w_y         = bus.x;
        w_nextState = S3N;
      end
      S2B: begin
        w_y         = ~bus.x;
        w_nextState = bus.x ? S3N : S3B;
      end
      S3N: begin
        w_y         = bus.x;
        w_nextState = S0;
      end
      S3B: begin
        w_y         = ~bus.x;
        w_nextState = S0;
      end
      default: begin
        w_y         = 1'b0;
        w_nextState = S0;
      end
    endcase
    if (!bus.x_valid) w_y = 1'b0;
  end

  // The current bit3 completes the nibble, so it joins the three shifted-in bits
  assign w_lastBit = (r_state == S3N) || (r_state == S3B);
  assign w_code    = {bus.x, r_codeSh};
  assign w_digit   = {w_y, r_ySh};
  assign w_codeErr = (w_code < 4'd3) || (w_code > 4'd12);

  always_comb begin
    w_stageNext = r_stage;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_cnt == CW'(i)) w_stageNext[i*4 +: 4] = w_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S0;
      r_bitIdx     <= 2'd0;
      r_codeSh     <= 3'd0;
      r_ySh        <= 3'd0;
      r_digit      <= 4'd0;
      r_digitValid <= 1'b0;
      r_codeErr    <= 1'b0;
      r_cnt        <= '0;
      r_sticky     <= 1'b0;
      r_stage      <= '0;
      r_bcdWord    <= '0;
      r_wordValid  <= 1'b0;
      r_wordErr    <= 1'b0;
    end else begin
      r_digitValid <= 1'b0;
      r_codeErr    <= 1'b0;
      r_wordValid  <= 1'b0;
      if (bus.x_valid) begin
        r_state  <= w_nextState;
        r_bitIdx <= r_bitIdx + 2'd1;
        r_codeSh <= {bus.x, r_codeSh[2:1]};
        r_ySh    <= {w_y, r_ySh[2:1]};
        if (w_lastBit) begin
          r_digit      <= w_digit;
          r_digitValid <= 1'b1;
          r_codeErr    <= w_codeErr;
          // Last digit of the word goes straight into bcd_word alongside the staged ones
          if (r_cnt == CW'(DIGITS - 1)) begin
            r_bcdWord   <= w_stageNext;
            r_wordValid <= 1'b1;
            r_wordErr   <= r_sticky | w_codeErr;
            r_cnt       <= '0;
            r_sticky    <= 1'b0;
          end else begin
            r_stage  <= w_stageNext;
            r_cnt    <= r_cnt + CW'(1);
            r_sticky <= r_sticky | w_codeErr;
          end
        end
      end
    end
  end

  assign bus.y           = w_y;
  assign bus.y_valid     = bus.x_valid;
  assign bus.bit_idx     = r_bitIdx;
  assign bus.digit       = r_digit;
  assign bus.digit_valid = r_digitValid;
  assign bus.code_err    = r_codeErr;
  assign bus.bcd_word    = r_bcdWord;
  assign bus.word_valid  = r_wordValid;
  assign bus.word_err    = r_wordErr;
endmodule

// File: tb/tb_xs3_to_bcd_serial_decoder.sv
// Directed bench for the serial Excess-3 to BCD decoder with hand-computed digits and words.
`timescale 1ns/1ps
module tb_xs3_to_bcd_serial_decoder;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectorCount = 0;
  int   missCount   = 0;

  always #5 clk = ~clk;

  xs3_to_bcd_serial_decoder_if #(.DIGITS(DIGITS)) bus ();

  xs3_to_bcd_serial_decoder #(.DIGITS(DIGITS)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reset is held for one edge with a bit offered at the same time; the bit must be dropped
  task automatic applyReset(input string name);
    @(negedge clk);
    reset       = 1'b1;
    bus.x       = 1'b1;
    bus.x_valid = 1'b1;
    @(negedge clk);
    checkOutput({name, " bit_idx"},     32'(bus.bit_idx),     32'd0);
    checkOutput({name, " digit"},       32'(bus.digit),       32'd0);
    checkOutput({name, " digit_valid"}, 32'(bus.digit_valid), 32'd0);
    checkOutput({name, " code_err"},    32'(bus.code_err),    32'd0);
    checkOutput({name, " bcd_word"},    32'(bus.bcd_word),    32'd0);
    checkOutput({name, " word_valid"},  32'(bus.word_valid),  32'd0);
    checkOutput({name, " word_err"},    32'(bus.word_err),    32'd0);
    reset       = 1'b0;
    bus.x_valid = 1'b0;
    #1;
    checkOutput({name, " idle y"},       32'(bus.y),       32'd0);
    checkOutput({name, " idle y_valid"}, 32'(bus.y_valid), 32'd0);
  endtask

  task automatic applyPartial(input logic [3:0] code, input int nBits);
    for (int k = 0; k < nBits; k++) begin
      @(negedge clk);
      bus.x       = code[k];
      bus.x_valid = 1'b1;
    end
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] code, input logic [3:0] expDigit,
                               input logic expErr, input logic expWordValid, input logic [15:0] expWord,
                               input logic expWordErr, input logic [3:0] bubbleMask);
    for (int k = 0; k < 4; k++) begin
      if (bubbleMask[k]) begin
        @(negedge clk);
        bus.x_valid = 1'b0;
        bus.x       = 1'($urandom_range(0, 1));
        #1;
        checkOutput({name, " bubble y"},       32'(bus.y),       32'd0);
        checkOutput({name, " bubble y_valid"}, 32'(bus.y_valid), 32'd0);
        checkOutput({name, " bubble bit_idx"}, 32'(bus.bit_idx), 32'(k));
      end
      @(negedge clk);
      bus.x       = code[k];
      bus.x_valid = 1'b1;
      #1;
      checkOutput({name, " y"},       32'(bus.y),       32'(expDigit[k]));
      checkOutput({name, " y_valid"}, 32'(bus.y_valid), 32'd1);
      checkOutput({name, " bit_idx"}, 32'(bus.bit_idx), 32'(k));
      if (k > 0) checkOutput({name, " digit_valid mid"}, 32'(bus.digit_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.x_valid = 1'b0;
    checkOutput({name, " digit"},       32'(bus.digit),       32'(expDigit));
    checkOutput({name, " digit_valid"}, 32'(bus.digit_valid), 32'd1);
    checkOutput({name, " code_err"},    32'(bus.code_err),    32'(expErr));
    checkOutput({name, " word_valid"},  32'(bus.word_valid),  32'(expWordValid));
    checkOutput({name, " bit_idx end"}, 32'(bus.bit_idx),     32'd0);
    if (expWordValid) begin
      checkOutput({name, " bcd_word"}, 32'(bus.bcd_word), 32'(expWord));
      checkOutput({name, " word_err"}, 32'(bus.word_err), 32'(expWordErr));
    end
  endtask

  // Digits 4,8,9,1 from codes 7,11,12,4, giving word 16'h1984
  task automatic applyWord1984(input string name);
    applyStimulus({name, ".d0"}, 4'b0111, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus({name, ".d1"}, 4'b1011, 4'h8, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus({name, ".d2"}, 4'b1100, 4'h9, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus({name, ".d3"}, 4'b0100, 4'h1, 1'b0, 1'b1, 16'h1984, 1'b0, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.x       = 1'b0;
    bus.x_valid = 1'b0;
    applyReset("rst0");

    applyStimulus("t1.code8",  4'b1000, 4'h5, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus("t2.code3",  4'b0011, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus("t2.code12", 4'b1100, 4'h9, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus("t3.code1",  4'b0001, 4'hE, 1'b1, 1'b1, 16'hE905, 1'b1, 4'b0000);
    applyStimulus("t3.code15", 4'b1111, 4'hC, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);

    applyReset("rst1");
    applyWord1984("t4.ok");
    applyStimulus("t4.err.d0", 4'b0111, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus("t4.err.d1", 4'b1011, 4'h8, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus("t4.err.d2", 4'b0001, 4'hE, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus("t4.err.d3", 4'b0100, 4'h1, 1'b0, 1'b1, 16'h1E84, 1'b1, 4'b0000);
    applyWord1984("t4.clean");

    applyStimulus("t5.bubbles", 4'b1000, 4'h5, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b1011);

    applyReset("rst2");
    applyPartial(4'b1000, 2);
    applyReset("t6.midDigit");
    applyStimulus("t6.p0", 4'b0111, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyStimulus("t6.p1", 4'b1011, 4'h8, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b0000);
    applyReset("t6.midWord");
    applyWord1984("t6.word");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
